// File: rtl/meter_pkg.sv
// Shared constants and types for the parking-meter button-to-command path.
// BTN_AMOUNT maps each button index to the time value it adds.
package meter_pkg;

  localparam int AMT_W = 14;
  localparam int N_AMT = 4;

  localparam logic [AMT_W-1:0] BTN_AMOUNT [N_AMT] = '{14'd50, 14'd150, 14'd200, 14'd500};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Buttons beyond the table carry a zero amount.
  function automatic logic [AMT_W-1:0] btn_amount(input logic [31:0] idx);
    logic [AMT_W-1:0] amt;
    amt = '0;
    if (idx < N_AMT) amt = BTN_AMOUNT[idx[1:0]];
    return amt;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set bit of pending at or after rr_ptr, wrapping.
// Zero latency; no flow control of its own.
module rr_arbiter #(
  parameter int N_BTN = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_BTN-1:0] pending,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic             grant_any,
  output logic [ID_W-1:0]  grant_idx
);

  logic [N_BTN-1:0] rot;

  // Rotate so that bit 0 of rot is the button rr_ptr points at.
  assign rot = N_BTN'({pending, pending} >> rr_ptr);

  always_comb begin
    grant_any = |rot;
    grant_idx = '0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      if (rot[k]) grant_idx = ID_W'((int'(rr_ptr) + k) % N_BTN);
    end
  end

endmodule

// File: rtl/meter_cmd_scheduler.sv
// Serializes button pulses into one command at a time; pulse to cmd_valid is 2 edges.
// cmd_ready stalls hold the command steady while new pulses queue as pending bits.
module meter_cmd_scheduler #(
  parameter int N_BTN = 4,
  parameter int GAP   = 2,
  localparam int ID_W = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_BTN-1:0]            btn_pulse,
  output logic                        cmd_valid,
  input  logic                        cmd_ready,
  output logic [ID_W-1:0]             cmd_id,
  output logic [meter_pkg::AMT_W-1:0] cmd_amount,
  output logic                        drop
);

  import meter_pkg::*;

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

  state_t           state;
  state_t           state_nxt;
  logic [GW-1:0]    gap_cnt;
  logic [GW-1:0]    gap_cnt_nxt;
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] pending_clr;
  logic [ID_W-1:0]  rr_ptr;
  logic             grant_any;
  logic [ID_W-1:0]  grant_idx;
  logic             xfer;
  logic             load_cmd;
  logic             drop_nxt;

  assign xfer        = cmd_valid & cmd_ready;
  assign pending_clr = xfer ? (N_BTN'(1) << cmd_id) : '0;
  // A pulse is lost only if its bit stays set through this edge anyway.
  assign drop_nxt    = |(btn_pulse & pending & ~pending_clr);

  rr_arbiter #(
    .N_BTN (N_BTN),
    .ID_W  (ID_W)
  ) u_arb (
    .pending   (pending),
    .rr_ptr    (rr_ptr),
    .grant_any (grant_any),
    .grant_idx (grant_idx)
  );

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    load_cmd    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          state_nxt = ISSUE;
          load_cmd  = 1'b1;
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          if (GAP > 0) begin
            state_nxt   = meter_pkg::GAP;
            gap_cnt_nxt = GAP_LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      meter_pkg::GAP: begin
        if (gap_cnt == '0) state_nxt = IDLE;
        else gap_cnt_nxt = gap_cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~pending_clr) | btn_pulse;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      rr_ptr     <= '0;
      cmd_valid  <= 1'b0;
      cmd_id     <= '0;
      cmd_amount <= '0;
      drop       <= 1'b0;
    end else begin
      state     <= state_nxt;
      gap_cnt   <= gap_cnt_nxt;
      cmd_valid <= (state_nxt == ISSUE);
      drop      <= drop_nxt;
      if (load_cmd) begin
        cmd_id     <= grant_idx;
        cmd_amount <= btn_amount(32'(grant_idx));
      end
      if (xfer) begin
        rr_ptr <= (cmd_id == ID_W'(N_BTN - 1)) ? '0 : cmd_id + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_meter_cmd_scheduler.sv
// Table-driven and hand-sequenced bench for meter_cmd_scheduler with a transfer scoreboard.
module tb_meter_cmd_scheduler;

  localparam int N_BTN  = 4;
  localparam int GAP    = 2;
  localparam int PERIOD = GAP + 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_BTN-1:0] btn_pulse;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_id;
  logic [13:0]      cmd_amount;
  logic             drop;

  meter_cmd_scheduler #(
    .N_BTN (N_BTN),
    .GAP   (GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_pulse  (btn_pulse),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_id     (cmd_id),
    .cmd_amount (cmd_amount),
    .drop       (drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mask;
    int         n;
    int         id0;
    int         id1;
    int         id2;
    int         id3;
    int         ptr;
  } vec_t;

  vec_t vecs[7];
  int   sb_q[$];
  int   xfer_ids[$];
  int   xfer_cyc[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   drop_cnt = 0;
  bit   sb_on    = 1'b1;

  function automatic int amt_of(input int id);
    case (id)
      0:       return 50;
      1:       return 150;
      2:       return 200;
      3:       return 500;
      default: return 0;
    endcase
  endfunction

  function automatic int vec_id(input vec_t v, input int k);
    case (k)
      0:       return v.id0;
      1:       return v.id1;
      2:       return v.id2;
      default: return v.id3;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    int e;
    if (drop) drop_cnt++;
    if (!reset && cmd_valid && cmd_ready) begin
      xfer_ids.push_back(int'(cmd_id));
      xfer_cyc.push_back(cyc);
      if (sb_on) begin
        if (sb_q.size() == 0) begin
          chk("xfer_unexpected_id", int'(cmd_id), -1);
        end else begin
          e = sb_q.pop_front();
          chk("xfer_id", int'(cmd_id), e);
          chk("xfer_amount", int'(cmd_amount), amt_of(e));
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    int quiet;
    n = 0;
    quiet = 0;
    while ((quiet < PERIOD + 2 || sb_q.size() != 0) && n < budget) begin
      step();
      n++;
      quiet = cmd_valid ? 0 : quiet + 1;
    end
    if (n >= budget) chk("drain_timeout_pending", sb_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    int base;
    int pcyc;
    int b3;
    int found;
    int nvalid;

    vecs[0] = '{4'b1000, 1, 3, 0, 0, 0, 0};
    vecs[1] = '{4'b1011, 3, 0, 1, 3, 0, 0};
    vecs[2] = '{4'b1111, 4, 0, 1, 2, 3, 0};
    vecs[3] = '{4'b0110, 2, 1, 2, 0, 0, 3};
    vecs[4] = '{4'b0101, 2, 0, 2, 0, 0, 3};
    vecs[5] = '{4'b0011, 2, 0, 1, 0, 0, 2};
    vecs[6] = '{4'b1001, 2, 3, 0, 0, 0, 1};

    reset     = 1'b1;
    btn_pulse = '0;
    cmd_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_valid", int'(cmd_valid), 0);
    chk("rst_id", int'(cmd_id), 0);
    chk("rst_amount", int'(cmd_amount), 0);
    chk("rst_drop", int'(drop), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    step();

    // Single pulse on button 2: latency and post-transfer gap.
    cmd_ready = 1'b1;
    d0 = drop_cnt;
    btn_pulse = 4'b0100;
    sb_q.push_back(2);
    step();
    btn_pulse = '0;
    chk("lat_e0_valid", int'(cmd_valid), 0);
    step();
    chk("lat_e1_valid", int'(cmd_valid), 1);
    chk("e1_id", int'(cmd_id), 2);
    chk("e1_amount", int'(cmd_amount), 200);
    step();
    chk("post_xfer_valid", int'(cmd_valid), 0);
    drain(40);
    chk("single_drop", drop_cnt - d0, 0);
    chk("single_ptr", int'(dut.rr_ptr), 3);

    // Simultaneous request sets at full throughput.
    for (int v = 0; v < 7; v++) begin
      d0 = drop_cnt;
      base = xfer_ids.size();
      btn_pulse = vecs[v].mask;
      for (int k = 0; k < vecs[v].n; k++) sb_q.push_back(vec_id(vecs[v], k));
      pcyc = cyc;
      step();
      btn_pulse = '0;
      drain(60);
      chk("vec_count", xfer_ids.size() - base, vecs[v].n);
      if (xfer_ids.size() - base == vecs[v].n) begin
        chk("vec_latency", xfer_cyc[base] - pcyc, 2);
        for (int k = 1; k < vecs[v].n; k++)
          chk("vec_spacing", xfer_cyc[base + k] - xfer_cyc[base + k - 1], PERIOD);
      end
      chk("vec_drop", drop_cnt - d0, 0);
      chk("vec_ptr", int'(dut.rr_ptr), vecs[v].ptr);
    end

    // Stalled button 1: stable outputs, one drop, queued button 0 follows.
    cmd_ready = 1'b0;
    d0 = drop_cnt;
    btn_pulse = 4'b0010;
    sb_q.push_back(1);
    step();
    btn_pulse = '0;
    step();
    for (int i = 0; i < 10; i++) begin
      btn_pulse = (i == 3) ? 4'b0010 : (i == 6) ? 4'b0001 : 4'b0000;
      if (i == 6) sb_q.push_back(0);
      step();
      chk("stall_valid", int'(cmd_valid), 1);
      chk("stall_id", int'(cmd_id), 1);
      chk("stall_amount", int'(cmd_amount), 150);
    end
    btn_pulse = '0;
    chk("stall_drop", drop_cnt - d0, 1);
    cmd_ready = 1'b1;
    drain(60);
    chk("stall_drop_total", drop_cnt - d0, 1);
    chk("stall_ptr", int'(dut.rr_ptr), 1);

    // Pulse coincident with its own transfer edge is kept.
    cmd_ready = 1'b0;
    d0 = drop_cnt;
    base = xfer_ids.size();
    btn_pulse = 4'b0010;
    sb_q.push_back(1);
    step();
    btn_pulse = '0;
    step();
    chk("coin_valid", int'(cmd_valid), 1);
    cmd_ready = 1'b1;
    btn_pulse = 4'b0010;
    sb_q.push_back(1);
    step();
    btn_pulse = '0;
    drain(60);
    chk("coin_count", xfer_ids.size() - base, 2);
    if (xfer_ids.size() - base == 2)
      chk("coin_spacing", xfer_cyc[base + 1] - xfer_cyc[base], PERIOD);
    chk("coin_drop", drop_cnt - d0, 0);
    chk("coin_ptr", int'(dut.rr_ptr), 2);

    // Fairness: button 0 hammering must not starve button 3.
    sb_on = 1'b0;
    d0 = drop_cnt;
    b3 = 0;
    cmd_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      btn_pulse = {(i == 8), 2'b00, (i < 20)};
      if (i == 8) b3 = xfer_ids.size();
      step();
    end
    btn_pulse = '0;
    drain(60);
    found = 0;
    for (int k = b3; k < xfer_ids.size() && k < b3 + 2; k++)
      if (xfer_ids[k] == 3) found = 1;
    chk("fair_btn3", found, 1);
    chk("fair_drop_seen", int'(drop_cnt > d0), 1);
    sb_on = 1'b1;

    // Asynchronous reset while a command is presented.
    cmd_ready = 1'b0;
    btn_pulse = 4'b0111;
    step();
    btn_pulse = '0;
    step();
    chk("pre_rst_valid", int'(cmd_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", int'(cmd_valid), 0);
    chk("arst_id", int'(cmd_id), 0);
    chk("arst_amount", int'(cmd_amount), 0);
    step();
    step();
    reset = 1'b0;
    chk("arst_ptr", int'(dut.rr_ptr), 0);
    cmd_ready = 1'b1;
    nvalid = 0;
    base = xfer_ids.size();
    for (int i = 0; i < 16; i++) begin
      step();
      if (cmd_valid) nvalid++;
    end
    chk("post_rst_idle", nvalid, 0);
    chk("post_rst_xfers", xfer_ids.size() - base, 0);
    btn_pulse = 4'b0100;
    sb_q.push_back(2);
    step();
    btn_pulse = '0;
    drain(60);
    chk("post_rst_ptr", int'(dut.rr_ptr), 3);
    chk("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
